// File: rtl/huff_frame_ctrl.sv
// huff_frame_ctrl: loads one PIC_SIZE x PIC_SIZE frame into pixel memory, runs the encoder and
// forwards its words under out_stop backpressure. Optional encoder watchdog: HUFF_CTRL_TIMEOUT_EN.
module huff_frame_ctrl #(
  parameter int PIC_SIZE       = 64,
  parameter int PIC_ADDR_WIDTH = 12,
  parameter int OUT_CNT_WIDTH  = 13,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      axis_enable,
  input  logic [7:0]                s_axis_data,
  input  logic                      out_stop,
  output logic                      mem_we,
  output logic [PIC_ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]                mem_wdata,
  output logic                      enc_start,
  input  logic                      enc_valid,
  input  logic [14:0]               enc_data,
  input  logic                      enc_done,
  output logic                      enc_ready,
  output logic [14:0]               odata,
  output logic                      o_valid,
  output logic                      end_flag,
  output logic                      err,
  output logic [2:0]                now_state
);

  localparam int FRAME_PIX = PIC_SIZE * PIC_SIZE;
  // One spare bit so the counter can actually hold the 2*frame limit before saturating.
  localparam int OCNT_W = OUT_CNT_WIDTH + 1;
  localparam logic [PIC_ADDR_WIDTH-1:0] LAST_PIX = PIC_ADDR_WIDTH'(FRAME_PIX - 1);
  localparam logic [OCNT_W-1:0]         MAX_OUT  = OCNT_W'(2 * FRAME_PIX);

  if ((2 ** PIC_ADDR_WIDTH) < FRAME_PIX) begin : g_bad_addr_width
    $error("huff_frame_ctrl: PIC_ADDR_WIDTH cannot address a full frame");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("huff_frame_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ENC   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [PIC_ADDR_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic [OCNT_W-1:0]         out_cnt_q, out_cnt_d;
  logic                      err_q, err_d;
  logic                      mem_we_q, mem_we_d;
  logic [PIC_ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
  logic [7:0]                mem_wdata_q, mem_wdata_d;
  logic                      enc_start_q, enc_start_d;
  logic [14:0]               odata_q, odata_d;
  logic                      o_valid_q, o_valid_d;
  logic                      end_flag_q, end_flag_d;
  logic                      active_s, accept_s, xfer_s;

`ifdef HUFF_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  assign active_s  = (state_q == ST_ENC) || (state_q == ST_FLUSH);
  assign enc_ready = !(o_valid_q && out_stop);
  assign accept_s  = enc_valid && enc_ready && active_s;
  assign xfer_s    = o_valid_q && !out_stop;

  // Next-state, pixel write path and single-register output path
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    out_cnt_d   = out_cnt_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    enc_start_d = 1'b0;
    odata_d     = odata_q;
    o_valid_d   = o_valid_q;
`ifdef HUFF_CTRL_TIMEOUT_EN
    wd_d        = {WD_W{1'b0}};
`endif

    if (accept_s) begin
      odata_d   = enc_data;
      o_valid_d = 1'b1;
    end else if (xfer_s) begin
      o_valid_d = 1'b0;
    end else begin
      o_valid_d = o_valid_q;
    end

    // Words past the limit are still forwarded; only the error is raised.
    if (xfer_s) begin
      if (out_cnt_q == MAX_OUT) begin
        err_d = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + OCNT_W'(1);
      end
    end else begin
      out_cnt_d = out_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        pix_cnt_d = {PIC_ADDR_WIDTH{1'b0}};
        out_cnt_d = {OCNT_W{1'b0}};
        if (start) begin
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (axis_enable) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = pix_cnt_q;
          mem_wdata_d = s_axis_data;
          pix_cnt_d   = pix_cnt_q + PIC_ADDR_WIDTH'(1);
          if (pix_cnt_q == LAST_PIX) begin
            state_d     = ST_ENC;
            enc_start_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_ENC: begin
        if (enc_done) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_ENC;
        end
`ifdef HUFF_CTRL_TIMEOUT_EN
        if (enc_valid || enc_done) begin
          wd_d = {WD_W{1'b0}};
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FLUSH;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      ST_FLUSH: begin
        if (!o_valid_d) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    end_flag_d = (state_d == ST_DONE);
  end

  // State and output registers; every output returns to zero on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pix_cnt_q   <= {PIC_ADDR_WIDTH{1'b0}};
      out_cnt_q   <= {OCNT_W{1'b0}};
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= {PIC_ADDR_WIDTH{1'b0}};
      mem_wdata_q <= 8'd0;
      enc_start_q <= 1'b0;
      odata_q     <= 15'd0;
      o_valid_q   <= 1'b0;
      end_flag_q  <= 1'b0;
`ifdef HUFF_CTRL_TIMEOUT_EN
      wd_q        <= {WD_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      out_cnt_q   <= out_cnt_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      enc_start_q <= enc_start_d;
      odata_q     <= odata_d;
      o_valid_q   <= o_valid_d;
      end_flag_q  <= end_flag_d;
`ifdef HUFF_CTRL_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign enc_start = enc_start_q;
  assign odata     = odata_q;
  assign o_valid   = o_valid_q;
  assign end_flag  = end_flag_q;
  assign err       = err_q;
  assign now_state = state_q;

endmodule
